// File: rtl/bla_sub_pipe_pkg.sv
// Shared definitions for the pipelined borrow-lookahead subtractor.
// bla4_borrows returns {borrow_out, difference[3:0]} for one 4-bit group.
package bla_pkg;

  localparam int GROUP_W = 4;

  function automatic logic [GROUP_W:0] bla4_borrows(
    input logic [GROUP_W-1:0] a4,
    input logic [GROUP_W-1:0] b4,
    input logic               bin
  );
    logic [GROUP_W-1:0] p;
    logic [GROUP_W-1:0] g;
    logic [GROUP_W:0]   br;
    p = ~(a4 ^ b4);
    g = ~a4 & b4;
    // every borrow is a flat sum of products of p/g/bin, nothing ripples
    br[0] = bin;
    br[1] = g[0] | (p[0] & bin);
    br[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & bin);
    br[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & bin);
    br[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
          | (p[3] & p[2] & p[1] & p[0] & bin);
    return {br[4], a4 ^ b4 ^ br[GROUP_W-1:0]};
  endfunction

endpackage

// File: rtl/bla_sub_pipe_if.sv
// Operand and result handshake bundle for bla_sub_pipe.
// slave is the subtractor side, master is the producer/consumer side.
interface bla_sub_pipe_if #(
  parameter int WIDTH = 16
);
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             bin;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] d;
  logic             bout;
  logic             ovf;
  logic             out_valid;
  logic             out_ready;

  modport slave (
    input  a, b, bin, in_valid, out_ready,
    output in_ready, d, bout, ovf, out_valid
  );

  modport master (
    output a, b, bin, in_valid, out_ready,
    input  in_ready, d, bout, ovf, out_valid
  );
endinterface

// File: rtl/bla_sub_pipe_bla4_group.sv
// Combinational 4-bit borrow-lookahead subtract cell.
module bla4_group
  import bla_pkg::*;
(
  input  logic [GROUP_W-1:0] a,
  input  logic [GROUP_W-1:0] b,
  input  logic               bin,
  output logic [GROUP_W-1:0] d,
  output logic               bout
);

  assign {bout, d} = bla4_borrows(a, b, bin);

endmodule

// File: rtl/bla_sub_pipe.sv
// Pipelined subtractor d = a - b - bin, one 4-bit lookahead group per stage.
// Operands travel with the beat; each stage fills in its group of d.
module bla_sub_pipe
  import bla_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic           clk,
  input  logic           rst,
  bla_sub_pipe_if.slave  bus
);

  localparam int STAGES = WIDTH / GROUP_W;

  logic [STAGES-1:0]  v_q;
  logic [STAGES-1:0]  br_q;
  logic [WIDTH-1:0]   a_q   [STAGES];
  logic [WIDTH-1:0]   b_q   [STAGES];
  logic [WIDTH-1:0]   d_q   [STAGES];

  logic [STAGES:0]    en;
  logic [STAGES-1:0]  v_src;
  logic [STAGES-1:0]  br_src;
  logic [STAGES-1:0]  g_bout;
  logic [WIDTH-1:0]   a_src [STAGES];
  logic [WIDTH-1:0]   b_src [STAGES];
  logic [WIDTH-1:0]   d_src [STAGES];
  logic [WIDTH-1:0]   d_nxt [STAGES];
  logic [GROUP_W-1:0] g_d   [STAGES];

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    if (k == 0) begin : g_first
      assign v_src[k]  = bus.in_valid;
      assign br_src[k] = bus.bin;
      assign a_src[k]  = bus.a;
      assign b_src[k]  = bus.b;
      assign d_src[k]  = '0;
    end else begin : g_next
      assign v_src[k]  = v_q[k-1];
      assign br_src[k] = br_q[k-1];
      assign a_src[k]  = a_q[k-1];
      assign b_src[k]  = b_q[k-1];
      assign d_src[k]  = d_q[k-1];
    end

    bla4_group u_group (
      .a    (a_src[k][GROUP_W*k +: GROUP_W]),
      .b    (b_src[k][GROUP_W*k +: GROUP_W]),
      .bin  (br_src[k]),
      .d    (g_d[k]),
      .bout (g_bout[k])
    );
  end

  // a stage may load when it is empty or its contents move on this edge
  always_comb begin
    en         = '0;
    en[STAGES] = bus.out_ready;
    for (int k = STAGES - 1; k >= 0; k--) begin
      en[k] = ~v_q[k] | en[k+1];
    end
  end

  always_comb begin
    for (int k = 0; k < STAGES; k++) begin
      d_nxt[k] = d_src[k];
      d_nxt[k][GROUP_W*k +: GROUP_W] = g_d[k];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      v_q  <= '0;
      br_q <= '0;
      for (int k = 0; k < STAGES; k++) begin
        a_q[k] <= '0;
        b_q[k] <= '0;
        d_q[k] <= '0;
      end
    end else begin
      for (int k = 0; k < STAGES; k++) begin
        if (en[k]) begin
          v_q[k] <= v_src[k];
          if (v_src[k]) begin
            br_q[k] <= g_bout[k];
            a_q[k]  <= a_src[k];
            b_q[k]  <= b_src[k];
            d_q[k]  <= d_nxt[k];
          end
        end
      end
    end
  end

  assign bus.in_ready  = en[0];
  assign bus.out_valid = v_q[STAGES-1];
  assign bus.d         = d_q[STAGES-1];
  assign bus.bout      = br_q[STAGES-1];
  assign bus.ovf       = (a_q[STAGES-1][WIDTH-1] ^ b_q[STAGES-1][WIDTH-1])
                       & (a_q[STAGES-1][WIDTH-1] ^ d_q[STAGES-1][WIDTH-1]);

endmodule

// File: tb/tb_bla_sub_pipe.sv
// Scoreboard bench for bla_sub_pipe: the driver queues expected results on
// each accepted beat, the monitor pops and compares on each emitted beat.
module tb_bla_sub_pipe;

  localparam int WIDTH  = 16;
  localparam int STAGES = 4;

  typedef struct packed {
    logic [15:0] d;
    logic        bout;
    logic        ovf;
  } res_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  bla_sub_pipe_if #(.WIDTH(WIDTH)) bus();

  bla_sub_pipe #(.WIDTH(WIDTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  res_t sb[$];
  int   out_cyc[$];
  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;

  always @(posedge clk) cyc <= cyc + 1;

  logic [15:0] t4a [8] = '{16'h0005, 16'h0010, 16'h1000, 16'hFFFF, 16'h0000, 16'h7FFF, 16'h8000, 16'hABCD};
  logic [15:0] t4b [8] = '{16'h0003, 16'h0001, 16'h0001, 16'hFFFF, 16'h0000, 16'h8000, 16'h7FFF, 16'h1234};
  logic        t4c [8] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
  logic [15:0] t4d [8] = '{16'h0002, 16'h000F, 16'h0FFF, 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'h0001, 16'h9999};
  logic        t4o [8] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
  logic        t4v [8] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};

  logic [15:0] t5a [6] = '{16'h0100, 16'h0200, 16'h0300, 16'h0400, 16'h0500, 16'h0600};
  logic [15:0] t5b [6] = '{16'h0000, 16'h0001, 16'h0002, 16'h0003, 16'h0004, 16'h0005};
  logic [15:0] t5d [6] = '{16'h0100, 16'h01FF, 16'h02FE, 16'h03FD, 16'h04FC, 16'h05FB};

  function automatic res_t rr(input logic [15:0] d, input logic bo, input logic ov);
    rr = {d, bo, ov};
  endfunction

  function automatic res_t model(input logic [15:0] a, input logic [15:0] b, input logic bin);
    logic [16:0] diff;
    res_t r;
    diff   = {1'b0, a} - {1'b0, b} - {16'd0, bin};
    r.d    = diff[15:0];
    r.bout = diff[16];
    r.ovf  = (a[15] ^ b[15]) & (a[15] ^ r.d[15]);
    return r;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic send(input logic [15:0] a, input logic [15:0] b, input logic bin, input res_t exp);
    int waited;
    waited       = 0;
    bus.a        = a;
    bus.b        = b;
    bus.bin      = bin;
    bus.in_valid = 1'b1;
    forever begin
      @(negedge clk);
      if (bus.in_ready) begin
        sb.push_back(exp);
        break;
      end
      waited++;
      if (waited > 50) begin
        total++;
        bad++;
        $display("FAIL send_timeout: got in_ready=0 for %0d cycles want 1", waited);
        break;
      end
      tick();
    end
    tick();
    bus.in_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 200) begin
      tick();
      n++;
    end
    check("drain_empty", 32'(sb.size()), 0);
  endtask

  // monitor: compare every emitted beat and hold-stability while stalled
  initial begin
    res_t cur;
    res_t exp;
    res_t held_val;
    logic held;
    held = 1'b0;
    held_val = '0;
    forever begin
      @(negedge clk);
      cur = {bus.d, bus.bout, bus.ovf};
      if (held && bus.out_valid) check("hold_stable", 32'(cur), 32'(held_val));
      if (bus.out_valid && bus.out_ready) begin
        out_cyc.push_back(cyc);
        if (sb.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_out: got %h want none", cur);
        end else begin
          exp = sb.pop_front();
          check("result", 32'(cur), 32'(exp));
        end
      end
      held     = bus.out_valid && !bus.out_ready;
      held_val = cur;
    end
  end

  initial begin
    int c0;
    int n_acc;
    int n_seen;
    int sent;
    int guard;
    logic last_rdy;
    logic accepted;
    logic [15:0] ra;
    logic [15:0] rb;
    logic rbin;

    bus.a = '0; bus.b = '0; bus.bin = 1'b0; bus.in_valid = 1'b0; bus.out_ready = 1'b1;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #2 rst = 1'b0;

    @(negedge clk);
    check("rst_out_valid", 32'(bus.out_valid), 0);
    check("rst_d", 32'(bus.d), 0);
    check("rst_bout", 32'(bus.bout), 0);
    check("rst_ovf", 32'(bus.ovf), 0);
    check("rst_in_ready", 32'(bus.in_ready), 1);
    tick();

    out_cyc.delete();
    c0 = cyc;
    send(16'h1234, 16'h0234, 1'b0, rr(16'h1000, 1'b0, 1'b0));
    drain();
    if (out_cyc.size() == 0) check("latency_single", 32'(out_cyc.size()), 1);
    else check("latency_single", 32'(out_cyc[0] - c0), STAGES);

    send(16'h0000, 16'h0001, 1'b0, rr(16'hFFFF, 1'b1, 1'b0));
    send(16'h5A5A, 16'h5A5A, 1'b1, rr(16'hFFFF, 1'b1, 1'b0));
    send(16'h8000, 16'h0001, 1'b0, rr(16'h7FFF, 1'b0, 1'b1));
    send(16'h7FFF, 16'hFFFF, 1'b0, rr(16'h8000, 1'b1, 1'b1));
    drain();

    out_cyc.delete();
    c0 = cyc;
    for (int i = 0; i < 8; i++) send(t4a[i], t4b[i], t4c[i], rr(t4d[i], t4o[i], t4v[i]));
    drain();
    check("stream_count", 32'(out_cyc.size()), 8);
    if (out_cyc.size() == 8) begin
      check("stream_first", 32'(out_cyc[0] - c0), STAGES);
      for (int i = 1; i < 8; i++) check("stream_gap", 32'(out_cyc[i] - out_cyc[i-1]), 1);
    end

    bus.out_ready = 1'b0;
    n_acc = 0;
    last_rdy = 1'b1;
    for (int c = 0; c < 10; c++) begin
      bus.a = t5a[n_acc]; bus.b = t5b[n_acc]; bus.bin = 1'b0;
      bus.in_valid = 1'b1;
      @(negedge clk);
      last_rdy = bus.in_ready;
      if (bus.in_ready) begin
        sb.push_back(rr(t5d[n_acc], 1'b0, 1'b0));
        n_acc++;
      end
      tick();
    end
    bus.in_valid = 1'b0;
    check("stall_accepts", 32'(n_acc), 4);
    check("stall_in_ready", 32'(last_rdy), 0);
    check("stall_out_valid", 32'(bus.out_valid), 1);
    bus.out_ready = 1'b1;
    send(t5a[4], t5b[4], 1'b0, rr(t5d[4], 1'b0, 1'b0));
    send(t5a[5], t5b[5], 1'b0, rr(t5d[5], 1'b0, 1'b0));
    drain();

    send(16'h1111, 16'h0001, 1'b0, rr(16'h1110, 1'b0, 1'b0));
    send(16'h2222, 16'h0002, 1'b0, rr(16'h2220, 1'b0, 1'b0));
    send(16'h3333, 16'h0003, 1'b0, rr(16'h3330, 1'b0, 1'b0));
    rst = 1'b1;
    tick();
    rst = 1'b0;
    sb.delete();
    @(negedge clk);
    check("flush_out_valid", 32'(bus.out_valid), 0);
    check("flush_d", 32'(bus.d), 0);
    check("flush_in_ready", 32'(bus.in_ready), 1);
    n_seen = 0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (bus.out_valid) n_seen++;
    end
    check("flush_no_stale", 32'(n_seen), 0);
    tick();

    sent = 0;
    guard = 0;
    accepted = 1'b0;
    ra = '0; rb = '0; rbin = 1'b0;
    while (sent < 200 && guard < 5000) begin
      bus.out_ready = ($urandom_range(0, 3) != 0);
      if (!bus.in_valid && $urandom_range(0, 3) != 0) begin
        ra   = 16'($urandom);
        rb   = 16'($urandom);
        rbin = 1'($urandom_range(0, 1));
        bus.a = ra; bus.b = rb; bus.bin = rbin;
        bus.in_valid = 1'b1;
      end
      @(negedge clk);
      accepted = bus.in_valid && bus.in_ready;
      if (accepted) begin
        sb.push_back(model(ra, rb, rbin));
        sent++;
      end
      tick();
      if (accepted) bus.in_valid = 1'b0;
      guard++;
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    check("rand_sent", 32'(sent), 200);
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
